// File: rtl/usr_pkg.sv
// Shared op codes, FSM state encoding and op classification for the universal shift register.
package usr_pkg;

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;
  localparam logic [2:0] OP_ASR  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Only the shift/rotate family may be repeated as a multi-step operation.
  function automatic logic isShiftOp(input logic [2:0] op);
    return (op >= OP_SHL) && (op <= OP_ASR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// One step of the register: next contents for any op code, used for both idle ops and busy steps.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sinL_i,
  input  logic             sinR_i,
  output logic [WIDTH-1:0] q_o
);

  always_comb begin
    q_o = q_i;
    case (op_i)
      OP_LOAD: q_o = d_i;
      OP_SHL:  q_o = {q_i[WIDTH-2:0], sinR_i};
      OP_SHR:  q_o = {sinL_i, q_i[WIDTH-1:1]};
      OP_ROL:  q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      OP_ROR:  q_o = {q_i[0], q_i[WIDTH-1:1]};
      OP_ASR:  q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      OP_CLR:  q_o = '0;
      default: q_o = q_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: single-cycle ops when idle, plus multi-step shift/rotate with busy/done.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int              AMT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [AMT_W-1:0] cnt_q;
  logic [AMT_W-1:0] cnt_d;
  logic [2:0]       opLat_q;
  logic [2:0]       stepOp;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             busy_q;
  logic             done_q;

  // While busy the latched op drives the step logic, so op changes on the port are ignored.
  assign stepOp = (state_q == ST_BUSY) ? opLat_q : op;
  assign cnt_d  = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;

  usr_step #(.WIDTH(WIDTH)) uStep (
    .op_i   (stepOp),
    .q_i    (data_q),
    .d_i    (d),
    .sinL_i (sin_l),
    .sinR_i (sin_r),
    .q_o    (data_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= RST_VAL;
      cnt_q   <= '0;
      opLat_q <= OP_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            if (start && isShiftOp(op)) begin
              if (amt == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= ST_BUSY;
                busy_q  <= 1'b1;
                cnt_q   <= cnt_d;
                opLat_q <= op;
              end
            end else begin
              data_q <= data_d;
            end
          end
        end
        ST_BUSY: begin
          if (en) begin
            data_q <= data_d;
            cnt_q  <= cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign q      = data_q;
  assign sout_l = data_q[WIDTH-1];
  assign sout_r = data_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: constant vectors, hand sequences, then random ops against a model.
module tb_universal_shift_reg;

  logic       clk;
  logic       rstN;
  logic       en;
  logic [2:0] op;
  logic       start;
  logic [3:0] amt;
  logic [7:0] d;
  logic       sinL;
  logic       sinR;
  logic [7:0] q;
  logic       soutL;
  logic       soutR;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  int mq = 0;
  int mRemain = 0;
  int mOp = 0;
  int mDone = 0;
  bit modelCheck = 0;

  int busyCnt;
  int doneCnt;
  bit doneSeen;

  typedef struct {
    logic [2:0] op;
    logic       sinL;
    logic       sinR;
    logic [7:0] expQ;
    string      name;
  } vec_t;

  vec_t vecs[7];

  universal_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk    (clk),
    .rst_n  (rstN),
    .en     (en),
    .op     (op),
    .start  (start),
    .amt    (amt),
    .d      (d),
    .sin_l  (sinL),
    .sin_r  (sinR),
    .q      (q),
    .sout_l (soutL),
    .sout_r (soutR),
    .busy   (busy),
    .done   (done)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a stuck run still ends with a report.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference behaviour of one op on an 8-bit value, written as plain arithmetic.
  function automatic int refOp(int opc, int v, int dd, int sl, int sr);
    int r;
    case (opc)
      0: r = v;
      1: r = dd;
      2: r = (v * 2 + sr) % 256;
      3: r = v / 2 + sl * 128;
      4: r = (v * 2) % 256 + v / 128;
      5: r = v / 2 + (v % 2) * 128;
      6: r = v / 2 + (v / 128) * 128;
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic modelReset();
    mq = 0;
    mRemain = 0;
    mOp = 0;
    mDone = 0;
  endtask

  // Model: mRemain counts steps still owed by an accepted start; zero means idle.
  task automatic modelEdge();
    mDone = 0;
    if (mRemain > 0) begin
      if (en) begin
        mq = refOp(mOp, mq, int'(d), int'(sinL), int'(sinR));
        mRemain = mRemain - 1;
        if (mRemain == 0) mDone = 1;
      end
    end else if (en) begin
      if (start && op >= 3'd2 && op <= 3'd6) begin
        if (amt == 4'd0) mDone = 1;
        else begin
          mOp = int'(op);
          mRemain = (int'(amt) > 8) ? 8 : int'(amt);
        end
      end else begin
        mq = refOp(int'(op), mq, int'(d), int'(sinL), int'(sinR));
      end
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic e, input logic s,
                               input logic [3:0] a, input logic [7:0] dd,
                               input logic sl, input logic sr);
    op = o;
    en = e;
    start = s;
    amt = a;
    d = dd;
    sinL = sl;
    sinR = sr;
  endtask

  // One rising edge; outputs are sampled 1ns later, away from the edge.
  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    if (modelCheck) begin
      checkOutput("rand_q", int'(q), mq);
      checkOutput("rand_busy", int'(busy), (mRemain > 0) ? 1 : 0);
      checkOutput("rand_done", int'(done), mDone);
      checkOutput("rand_sout_l", int'(soutL), mq / 128);
      checkOutput("rand_sout_r", int'(soutR), mq % 2);
    end
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before the next edge.
  task automatic midCycleReset(input string name);
    #2;
    rstN = 1'b0;
    modelReset();
    #1;
    checkOutput({name, "_q"}, int'(q), 8'h00);
    checkOutput({name, "_busy"}, int'(busy), 0);
    checkOutput({name, "_done"}, int'(done), 0);
    rstN = 1'b1;
  endtask

  task automatic loadValue(input logic [7:0] v);
    applyStimulus(3'd1, 1'b1, 1'b0, 4'd0, v, 1'b0, 1'b0);
    tick();
  endtask

  // Steps with the current inputs until done is seen, bounded to 20 edges.
  task automatic runUntilDone();
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      busyCnt += int'(busy);
      doneCnt += int'(done);
      if (done) begin
        doneSeen = 1;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] rolSeq[3];
    rolSeq[0] = 8'h03;
    rolSeq[1] = 8'h06;
    rolSeq[2] = 8'h0C;

    vecs[0] = '{3'd2, 1'b0, 1'b1, 8'h4B, "shl"};
    vecs[1] = '{3'd3, 1'b0, 1'b0, 8'h52, "shr"};
    vecs[2] = '{3'd4, 1'b0, 1'b0, 8'h4B, "rol"};
    vecs[3] = '{3'd5, 1'b0, 1'b0, 8'hD2, "ror"};
    vecs[4] = '{3'd6, 1'b0, 1'b0, 8'hD2, "asr"};
    vecs[5] = '{3'd7, 1'b0, 1'b0, 8'h00, "clr"};
    vecs[6] = '{3'd0, 1'b0, 1'b0, 8'hA5, "hold"};

    rstN = 1'b0;
    applyStimulus(3'd0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("reset_q", int'(q), 8'h00);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    rstN = 1'b1;

    loadValue(8'hA5);
    checkOutput("pre_reset_load", int'(q), 8'hA5);
    midCycleReset("async_reset");

    loadValue(8'hA5);
    checkOutput("load_a5", int'(q), 8'hA5);
    applyStimulus(3'd1, 1'b0, 1'b0, 4'd0, 8'hFF, 1'b0, 1'b0);
    tick();
    checkOutput("load_disabled", int'(q), 8'hA5);

    $display("[TB] single-cycle op vectors");
    for (int i = 0; i < 7; i++) begin
      loadValue(8'hA5);
      applyStimulus(vecs[i].op, 1'b1, 1'b0, 4'd0, 8'h00, vecs[i].sinL, vecs[i].sinR);
      tick();
      checkOutput({"op_", vecs[i].name}, int'(q), int'(vecs[i].expQ));
      checkOutput({"op_", vecs[i].name, "_sout_l"}, int'(soutL), int'(vecs[i].expQ[7]));
      checkOutput({"op_", vecs[i].name, "_sout_r"}, int'(soutR), int'(vecs[i].expQ[0]));
    end

    $display("[TB] multi-step rotate");
    loadValue(8'h81);
    applyStimulus(3'd4, 1'b1, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("rol3_start_q", int'(q), 8'h81);
    checkOutput("rol3_start_busy", int'(busy), 1);
    applyStimulus(3'd0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("rol3_step%0d_q", i + 1), int'(q), int'(rolSeq[i]));
      checkOutput($sformatf("rol3_step%0d_busy", i + 1), int'(busy), (i < 2) ? 1 : 0);
      checkOutput($sformatf("rol3_step%0d_done", i + 1), int'(done), (i == 2) ? 1 : 0);
    end
    tick();
    checkOutput("rol3_done_clears", int'(done), 0);

    $display("[TB] multi-step shift with stall");
    loadValue(8'hF0);
    busyCnt = 0;
    doneCnt = 0;
    doneSeen = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 0) applyStimulus(3'd3, 1'b1, 1'b1, 4'd4, 8'h00, 1'b0, 1'b0);
      else applyStimulus(3'd1, !(c == 3 || c == 4), 1'b1, 4'd1, 8'h55, 1'b0, 1'b1);
      tick();
      busyCnt += int'(busy);
      doneCnt += int'(done);
      if (done) begin
        doneSeen = 1;
        break;
      end
    end
    checkOutput("stall_done_seen", int'(doneSeen), 1);
    checkOutput("stall_busy_cycles", busyCnt, 6);
    checkOutput("stall_done_pulses", doneCnt, 1);
    checkOutput("stall_q", int'(q), 8'h0F);
    applyStimulus(3'd0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("stall_done_clears", int'(done), 0);

    $display("[TB] boundary counts");
    loadValue(8'hFF);
    applyStimulus(3'd2, 1'b1, 1'b1, 4'd12, 8'h00, 1'b0, 1'b0);
    tick();
    busyCnt = int'(busy);
    doneCnt = 0;
    applyStimulus(3'd0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    runUntilDone();
    checkOutput("clamp_done_seen", int'(doneSeen), 1);
    checkOutput("clamp_busy_cycles", busyCnt, 8);
    checkOutput("clamp_q", int'(q), 8'h00);

    loadValue(8'h3C);
    applyStimulus(3'd3, 1'b1, 1'b1, 4'd0, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("amt0_q", int'(q), 8'h3C);
    checkOutput("amt0_busy", int'(busy), 0);
    checkOutput("amt0_done", int'(done), 1);
    applyStimulus(3'd0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("amt0_done_clears", int'(done), 0);
    checkOutput("amt0_busy_after", int'(busy), 0);

    applyStimulus(3'd1, 1'b1, 1'b1, 4'd3, 8'h99, 1'b0, 1'b0);
    tick();
    checkOutput("start_load_q", int'(q), 8'h99);
    checkOutput("start_load_busy", int'(busy), 0);
    checkOutput("start_load_done", int'(done), 0);

    $display("[TB] abort and back-to-back");
    loadValue(8'h5A);
    applyStimulus(3'd5, 1'b1, 1'b1, 4'd5, 8'h00, 1'b0, 1'b0);
    tick();
    applyStimulus(3'd0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("abort_step1_q", int'(q), 8'h2D);
    midCycleReset("abort");
    doneCnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      doneCnt += int'(done);
    end
    checkOutput("abort_no_done", doneCnt, 0);
    checkOutput("abort_q_after", int'(q), 8'h00);

    loadValue(8'h11);
    applyStimulus(3'd4, 1'b1, 1'b1, 4'd2, 8'h00, 1'b0, 1'b0);
    tick();
    busyCnt = 0;
    doneCnt = 0;
    applyStimulus(3'd0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    runUntilDone();
    checkOutput("b2b_first_done", int'(doneSeen), 1);
    checkOutput("b2b_first_q", int'(q), 8'h44);
    applyStimulus(3'd4, 1'b1, 1'b1, 4'd1, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("b2b_second_busy", int'(busy), 1);
    checkOutput("b2b_second_done", int'(done), 0);
    applyStimulus(3'd0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("b2b_second_done_pulse", int'(done), 1);
    checkOutput("b2b_second_q", int'(q), 8'h88);

    $display("[TB] randomized ops against reference model");
    modelCheck = 1;
    for (int i = 0; i < 600; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                    8'($urandom), 1'($urandom), 1'($urandom));
      tick();
      if ($urandom_range(0, 60) == 0) begin
        modelCheck = 0;
        midCycleReset("rand_reset");
        modelCheck = 1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with enable, parallel load, clear, shift, rotate and arithmetic-shift modes.
- Supports single-cycle operations and multi-cycle shift/rotate by a programmable amount, with a busy/done handshake.
- Serial in/out at both ends allows it to serve as a serializer/deserializer or a general datapath register in later labs.

Parameters:
- WIDTH, 8, register width in bits (>= 2)
- RST_VAL, 0, value of q on reset (WIDTH bits)
- AMT_W, $clog2(WIDTH+1), width of the amt port; derived, not to be overridden

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  enable for IDLE ops; acts as step-enable (stall when 0) while busy
- op  in  3  operation code (see Behaviour)
- start  in  1  request a multi-step shift/rotate of amt steps
- amt  in  AMT_W  step count for start; values > WIDTH are clamped to WIDTH
- d  in  WIDTH  parallel load data
- sin_l  in  1  serial input into MSB for SHR
- sin_r  in  1  serial input into LSB for SHL
- q  out  WIDTH  register contents
- sout_l  out  1  q[WIDTH-1], combinational from q
- sout_r  out  1  q[0], combinational from q
- busy  out  1  high while a multi-step operation is in progress
- done  out  1  one-cycle pulse when a start request completes

Behaviour:
- Reset (rst_n=0, asynchronous): q=RST_VAL, state=IDLE, busy=0, done=0, step counter=0. Reset during BUSY aborts the operation with no done pulse.
- Op codes:
  - 0 HOLD: q unchanged
  - 1 LOAD: q=d
  - 2 SHL: q={q[W-2:0],sin_r}
  - 3 SHR: q={sin_l,q[W-1:1]}
  - 4 ROL: q={q[W-2:0],q[W-1]}
  - 5 ROR: q={q[0],q[W-1:1]}
  - 6 ASR: q={q[W-1],q[W-1:1]}
  - 7 CLR: q=0 (not RST_VAL)
- IDLE, en=0: q holds; start is ignored.
- IDLE, en=1, start=0: op is applied at this edge (1-cycle latency). done stays 0.
- IDLE, en=1, start=1, op in 2..6, amt!=0:
  - At this edge: latch op and cnt=min(amt,WIDTH), go to BUSY, busy=1. q is not changed at the start edge.
- IDLE, en=1, start=1, op in 2..6, amt=0: no change to q, stay IDLE, done=1 for the next cycle, busy never rises.
- IDLE, en=1, start=1, op in {0,1,7}: start is ignored; op is applied as a single-cycle op and done stays 0.
- BUSY:
  - On each edge with en=1, apply the latched op once and decrement cnt. sin_l/sin_r are sampled live at each step.
  - On edges with en=0, no step is taken and cnt holds.
  - op, start, amt and d are ignored while busy.
- Completion: the edge performing the final step (cnt 1->0) sets state=IDLE, busy=0, done=1. done clears on the following edge.
- Timing: start sampled at edge k with no stalls gives steps at k+1..k+n, and busy=1 and done=0 in the cycles after edges k..k+n-1. busy=0 and done=1 in the cycle after edge k+n.
- A new start is accepted in the cycle where done=1, because the block is back in IDLE.
- Arithmetic: all ops are width-preserving; no carry out beyond sout_l/sout_r.

Decomposition:
- Package usr_pkg:
  - op-code localparams OP_HOLD..OP_CLR (3-bit)
  - state encoding ST_IDLE/ST_BUSY
- Sub-module usr_step: combinational, takes (op, q, sin_l, sin_r) and returns next q for ops 0..7. It is shared by the IDLE single-cycle path and the BUSY step path.
- Top module: state register, step counter, amt clamp, busy/done logic.

Test Plan (WIDTH=8, RST_VAL=0):
- Reset and enable: rst_n=0 asynchronously mid-cycle → q=8'h00, busy=0, done=0 immediately. Release, LOAD d=8'hA5 en=1 → q=8'hA5 after 1 edge. LOAD d=8'hFF en=0 → q stays 8'hA5.
- Single ops from q=8'hA5, each starting from a fresh load of 8'hA5:
  - SHL sin_r=1 → 8'h4B
  - SHR sin_l=0 → 8'h52
  - ROL → 8'h4B
  - ROR → 8'hD2
  - ASR → 8'hD2
  - CLR → 8'h00
  - HOLD → 8'hA5
- Multi-step rotate: q=8'h81, start ROL amt=3 → q sequence 03, 06, 0C. busy high for 3 cycles, done high exactly 1 cycle, final q=8'h0C.
- Multi-step with stall: q=8'hF0, start SHR amt=4 sin_l=0, en=0 for 2 cycles mid-operation → 6 busy cycles, q=8'h0F, single done pulse. Changing op/d while busy has no effect.
- Boundary counts:
  - q=8'hFF, start SHL amt=12 sin_r=0 → clamped to 8 steps, q=8'h00.
  - start with amt=0 → q unchanged, done pulse, busy stays 0.
  - start with op=LOAD → q=d in 1 cycle, no done pulse.
- Abort and back-to-back: rst_n pulsed low during step 2 of a 5-step ROR → q=8'h00, busy=0, no done pulse. A second start issued in the done cycle of a prior op is accepted (busy=1 on the next cycle).
